// File: rtl/mmio_perf_counters_pkg.sv
// Purpose: address map and offset decode shared by the perf counter unit and the CPU decoder.
// Latency: n/a (constants and a combinational helper).
// Backpressure: n/a.
package mmio_perf_counters_pkg;

  localparam logic [3:0]  MMIO_REGION      = 4'h8;
  localparam logic [31:0] MMIO_CYCLE_OFS   = 32'h0000_0010;
  localparam logic [31:0] MMIO_INSTRET_OFS = 32'h0000_0014;
  localparam logic [31:0] MMIO_RST_OFS     = 32'h0000_0018;
  localparam logic [31:0] MMIO_BR_TOT_OFS  = 32'h0000_001C;
  localparam logic [31:0] MMIO_BR_OK_OFS   = 32'h0000_0020;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CYCLE,
    SEL_INSTRET,
    SEL_RST,
    SEL_BR_TOT,
    SEL_BR_OK
  } mmio_sel_e;

  // Byte offset to register select; the low two address bits are dropped so
  // misaligned accesses land on the containing word.
  function automatic mmio_sel_e decode_ofs(input logic [31:0] ofs);
    logic [31:0] ofs_al;
    ofs_al = ofs & 32'hFFFF_FFFC;
    case (ofs_al)
      MMIO_CYCLE_OFS:   decode_ofs = SEL_CYCLE;
      MMIO_INSTRET_OFS: decode_ofs = SEL_INSTRET;
      MMIO_RST_OFS:     decode_ofs = SEL_RST;
      MMIO_BR_TOT_OFS:  decode_ofs = SEL_BR_TOT;
      MMIO_BR_OK_OFS:   decode_ofs = SEL_BR_OK;
      default:          decode_ofs = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_perf_counters_perf_cntr.sv
// Purpose: single wrapping event counter with synchronous clear.
// Latency: count visible one cycle after the enabling event.
// Backpressure: none; accepts an increment every cycle.
module perf_cntr #(
  parameter int CNTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [CNTR_W-1:0] cnt
);

  // Clear beats increment so a clear cycle drops that cycle's event; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNTR_W'(1);
    end
  end

endmodule

// File: rtl/mmio_perf_counters.sv
// Purpose: MMIO perf counters (cycles, retired insts, branches, correct branches) beside DMem.
// Latency: load data and hit flag registered, valid the cycle after mmio_ren.
// Backpressure: none; every load/store completes in one cycle.
module mmio_perf_counters
  import mmio_perf_counters_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          CNTR_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_ren,
  input  logic        mmio_wen,
  input  logic [3:0]  mmio_wmask,
  input  logic        inst_retire,
  input  logic        br_resolve,
  input  logic        br_correct,
  output logic [31:0] mmio_rdata,
  output logic        mmio_hit
);

  // Bits of a counter that fit on the 32-bit read bus.
  localparam int RW = (CNTR_W < 32) ? CNTR_W : 32;

  logic [31:0]       ofs;
  logic              region_hit;
  mmio_sel_e         sel;
  logic              clr;
  logic [31:0]       rd_nxt;
  logic [CNTR_W-1:0] cycle_cnt;
  logic [CNTR_W-1:0] instret_cnt;
  logic [CNTR_W-1:0] br_tot_cnt;
  logic [CNTR_W-1:0] br_ok_cnt;

  assign ofs        = mmio_addr - BASE_ADDR;
  assign region_hit = (mmio_addr[31:28] == BASE_ADDR[31:28]);
  assign sel        = region_hit ? decode_ofs(ofs) : SEL_NONE;
  // Any enabled byte lane of a store to the reset word clears everything.
  assign clr        = mmio_wen && (sel == SEL_RST) && (|mmio_wmask);

  perf_cntr #(.CNTR_W(CNTR_W)) u_cycle (
    .clk(clk), .rst(rst), .clr(clr), .inc(1'b1),                    .cnt(cycle_cnt)
  );
  perf_cntr #(.CNTR_W(CNTR_W)) u_instret (
    .clk(clk), .rst(rst), .clr(clr), .inc(inst_retire),             .cnt(instret_cnt)
  );
  perf_cntr #(.CNTR_W(CNTR_W)) u_br_tot (
    .clk(clk), .rst(rst), .clr(clr), .inc(br_resolve),              .cnt(br_tot_cnt)
  );
  perf_cntr #(.CNTR_W(CNTR_W)) u_br_ok (
    .clk(clk), .rst(rst), .clr(clr), .inc(br_resolve && br_correct), .cnt(br_ok_cnt)
  );

  // Read mux on pre-edge counter values, so a read alongside a clear sees the old count.
  always_comb begin
    rd_nxt = '0;
    case (sel)
      SEL_CYCLE:   rd_nxt[RW-1:0] = cycle_cnt[RW-1:0];
      SEL_INSTRET: rd_nxt[RW-1:0] = instret_cnt[RW-1:0];
      SEL_BR_TOT:  rd_nxt[RW-1:0] = br_tot_cnt[RW-1:0];
      SEL_BR_OK:   rd_nxt[RW-1:0] = br_ok_cnt[RW-1:0];
      default:     rd_nxt = '0;
    endcase
  end

  // Registered load return; data holds between loads, hit reflects only the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mmio_rdata <= '0;
      mmio_hit   <= 1'b0;
    end else begin
      mmio_hit <= mmio_ren && (sel != SEL_NONE);
      if (mmio_ren) begin
        mmio_rdata <= rd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mmio_perf_counters.sv
module tb_mmio_perf_counters;

  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INST = 32'h8000_0014;
  localparam logic [31:0] A_RST  = 32'h8000_0018;
  localparam logic [31:0] A_BTOT = 32'h8000_001C;
  localparam logic [31:0] A_BOK  = 32'h8000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mmio_addr;
  logic        mmio_ren, mmio_wen;
  logic [3:0]  mmio_wmask;
  logic        inst_retire, br_resolve, br_correct;
  logic [31:0] mmio_rdata, rdata_w;
  logic        mmio_hit, hit_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_perf_counters dut (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_ren(mmio_ren), .mmio_wen(mmio_wen),
    .mmio_wmask(mmio_wmask), .inst_retire(inst_retire), .br_resolve(br_resolve),
    .br_correct(br_correct), .mmio_rdata(mmio_rdata), .mmio_hit(mmio_hit)
  );

  // Narrow instance so counter wrap is reachable in a few cycles.
  mmio_perf_counters #(.CNTR_W(3)) dut_w (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_ren(mmio_ren), .mmio_wen(mmio_wen),
    .mmio_wmask(mmio_wmask), .inst_retire(inst_retire), .br_resolve(br_resolve),
    .br_correct(br_correct), .mmio_rdata(rdata_w), .mmio_hit(hit_w)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_lw(input logic [31:0] a);
    mmio_addr = a; mmio_ren = 1'b1;
    @(negedge clk);
    mmio_ren = 1'b0;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [3:0] m);
    mmio_addr = a; mmio_wen = 1'b1; mmio_wmask = m;
    @(negedge clk);
    mmio_wen = 1'b0; mmio_wmask = 4'h0;
  endtask

  task automatic test_reset;
    rst = 1'b0; mmio_addr = '0; mmio_ren = 0; mmio_wen = 0; mmio_wmask = 0;
    inst_retire = 0; br_resolve = 0; br_correct = 0;
    idle(2);
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %0h want 0", mmio_rdata); end
    n_cmp++; if (mmio_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", mmio_hit); end
    n_cmp++; if (rdata_w !== 32'd0) begin n_bad++; $display("FAIL reset_rdata_w: got %0h want 0", rdata_w); end
    rst = 1'b1;
  endtask

  task automatic test_idle_cycles;
    idle(20);
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd20) begin n_bad++; $display("FAIL idle_cycles: got %0d want 20", mmio_rdata); end
    n_cmp++; if (mmio_hit !== 1'b1) begin n_bad++; $display("FAIL idle_hit: got %b want 1", mmio_hit); end
  endtask

  task automatic test_instret;
    inst_retire = 1'b1;
    do_sw(A_RST, 4'hF);
    idle(10);
    inst_retire = 1'b0;
    do_lw(A_INST);
    n_cmp++; if (mmio_rdata !== 32'd10) begin n_bad++; $display("FAIL instret: got %0d want 10", mmio_rdata); end
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd11) begin n_bad++; $display("FAIL instret_cycle: got %0d want 11", mmio_rdata); end
  endtask

  task automatic test_branches;
    logic [1:0] pat [4];
    pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b11;
    do_sw(A_RST, 4'hF);
    for (int i = 0; i < 4; i++) begin
      br_resolve = pat[i][1]; br_correct = pat[i][0];
      @(negedge clk);
    end
    br_resolve = 0; br_correct = 0;
    do_lw(A_BTOT);
    n_cmp++; if (mmio_rdata !== 32'd3) begin n_bad++; $display("FAIL br_total: got %0d want 3", mmio_rdata); end
    do_lw(A_BOK);
    n_cmp++; if (mmio_rdata !== 32'd2) begin n_bad++; $display("FAIL br_correct: got %0d want 2", mmio_rdata); end
  endtask

  task automatic test_wrap;
    do_sw(A_RST, 4'hF);
    idle(6);
    do_lw(A_CYC);
    n_cmp++; if (rdata_w !== 32'd6) begin n_bad++; $display("FAIL wrap_pre: got %0d want 6", rdata_w); end
    do_lw(A_CYC);
    n_cmp++; if (rdata_w !== 32'd7) begin n_bad++; $display("FAIL wrap_max: got %0d want 7", rdata_w); end
    idle(1);
    do_lw(A_CYC);
    n_cmp++; if (rdata_w !== 32'd1) begin n_bad++; $display("FAIL wrap_post: got %0d want 1", rdata_w); end
    n_cmp++; if (mmio_rdata !== 32'd9) begin n_bad++; $display("FAIL wrap_wide: got %0d want 9", mmio_rdata); end
  endtask

  task automatic test_back_to_back;
    do_sw(A_RST, 4'hF);
    idle(5);
    do_lw(A_CYC);
    do_sw(A_RST, 4'hF);
    n_cmp++; if (mmio_rdata !== 32'd5) begin n_bad++; $display("FAIL b2b_hold: got %0d want 5", mmio_rdata); end
    n_cmp++; if (mmio_hit !== 1'b0) begin n_bad++; $display("FAIL b2b_hit: got %b want 0", mmio_hit); end
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL b2b_after_clr: got %0d want 0", mmio_rdata); end
    idle(4);
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd5) begin n_bad++; $display("FAIL same_pre: got %0d want 5", mmio_rdata); end
    // Load and clear issued together at the reset word.
    mmio_addr = A_RST; mmio_ren = 1; mmio_wen = 1; mmio_wmask = 4'hF;
    @(negedge clk);
    mmio_ren = 0; mmio_wen = 0; mmio_wmask = 0;
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL same_rdata: got %0d want 0", mmio_rdata); end
    n_cmp++; if (mmio_hit !== 1'b1) begin n_bad++; $display("FAIL same_hit: got %b want 1", mmio_hit); end
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL same_after_clr: got %0d want 0", mmio_rdata); end
  endtask

  task automatic test_decode;
    logic [31:0] addr [7];
    logic [31:0] exp_d [7];
    logic        exp_h [7];
    addr[0] = A_CYC;         exp_d[0] = 3; exp_h[0] = 1;
    addr[1] = 32'h8000_0024; exp_d[1] = 0; exp_h[1] = 0;
    addr[2] = 32'h8000_0013; exp_d[2] = 5; exp_h[2] = 1;
    addr[3] = 32'h0000_0010; exp_d[3] = 0; exp_h[3] = 0;
    addr[4] = 32'h8000_0011; exp_d[4] = 7; exp_h[4] = 1;
    addr[5] = A_RST;         exp_d[5] = 0; exp_h[5] = 1;
    addr[6] = 32'h8000_0012; exp_d[6] = 9; exp_h[6] = 1;
    do_sw(A_RST, 4'hF);
    idle(3);
    for (int i = 0; i < 7; i++) begin
      do_lw(addr[i]);
      n_cmp++; if (mmio_rdata !== exp_d[i] || mmio_hit !== exp_h[i]) begin
        n_bad++;
        $display("FAIL decode_%08h: got data %0d hit %b want data %0d hit %b",
                 addr[i], mmio_rdata, mmio_hit, exp_d[i], exp_h[i]);
      end
    end
    do_sw(A_CYC, 4'hF);
    do_sw(A_RST, 4'h0);
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd12) begin n_bad++; $display("FAIL ignored_writes: got %0d want 12", mmio_rdata); end
    do_sw(A_RST, 4'b0100);
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL sb_clear: got %0d want 0", mmio_rdata); end
  endtask

  task automatic test_async_reset;
    do_sw(A_RST, 4'hF);
    inst_retire = 1'b1;
    idle(3);
    inst_retire = 1'b0;
    do_lw(A_INST);
    n_cmp++; if (mmio_rdata !== 32'd3) begin n_bad++; $display("FAIL pre_rst_instret: got %0d want 3", mmio_rdata); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (mmio_rdata !== 32'd0 || mmio_hit !== 1'b0) begin
      n_bad++; $display("FAIL async_rst: got data %0d hit %b want 0 0", mmio_rdata, mmio_hit);
    end
    idle(2);
    rst = 1'b1;
    idle(4);
    do_lw(A_CYC);
    n_cmp++; if (mmio_rdata !== 32'd4) begin n_bad++; $display("FAIL resume_cycle: got %0d want 4", mmio_rdata); end
    do_lw(A_INST);
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_bad++; $display("FAIL resume_instret: got %0d want 0", mmio_rdata); end
  endtask

  initial begin
    test_reset();
    test_idle_cycles();
    test_instret();
    test_branches();
    test_wrap();
    test_back_to_back();
    test_decode();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
